// File: rtl/decnx_seq.sv
// rtl/decnx_seq.sv - N-to-2^N registered one-hot decoder with enable; auto-advance scan mode
// is built only when DECNX_SCAN_EN is defined.
module decnx_seq #(
   parameter int N     = 3,
   parameter int DIV_W = 4
) (
   input  logic              CLK,
   input  logic              RSTB,
   input  logic [N-1:0]      A,
   input  logic              LOAD,
   input  logic              EN,
   input  logic              SCAN,
   input  logic [DIV_W-1:0]  DIV,
   output logic [2**N-1:0]   Y,
   output logic [N-1:0]      IDX,
   output logic              BUSY,
   output logic              WRAPPED
);
   localparam int M = 2**N;

   logic [N-1:0] idx;
   logic [N-1:0] idx_next;
   logic [M-1:0] y_next;

   // Y is decoded from the post-update index so Y and IDX always agree.
   always_comb begin
      y_next = '0;
      y_next[idx_next] = EN;
   end

   assign IDX = idx;

`ifdef DECNX_SCAN_EN
   typedef enum logic {S_IDLE, S_SCAN} state_t;

   state_t           state;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_next;
   logic             step;
   logic             wrap_next;

   // LOAD outranks everything but reset; leaving SCAN drops the prescaler and holds idx.
   always_comb begin
      idx_next = idx;
      cnt_next = cnt;
      step     = 1'b0;
      if (LOAD) begin
         idx_next = A;
         cnt_next = '0;
      end else if (state == S_SCAN && !SCAN) begin
         cnt_next = '0;
      end else if (EN && state == S_SCAN) begin
         if (cnt >= DIV) begin
            step     = 1'b1;
            idx_next = idx + 1'b1;
            cnt_next = '0;
         end else begin
            cnt_next = cnt + 1'b1;
         end
      end
   end

   assign wrap_next = step && (idx == '1);

   always_ff @(posedge CLK) begin
      if (!RSTB) begin
         state   <= S_IDLE;
         idx     <= '0;
         cnt     <= '0;
         Y       <= '0;
         WRAPPED <= 1'b0;
      end else begin
         idx     <= idx_next;
         cnt     <= cnt_next;
         Y       <= y_next;
         WRAPPED <= wrap_next;
         case (state)
            S_IDLE: if (SCAN && EN && !LOAD) state <= S_SCAN;
            S_SCAN: if (!SCAN) state <= S_IDLE;
         endcase
      end
   end

   assign BUSY = (state == S_SCAN);
`else
   logic unused_scan;

   assign unused_scan = ^{SCAN, DIV};
   assign idx_next    = LOAD ? A : idx;

   always_ff @(posedge CLK) begin
      if (!RSTB) begin
         idx <= '0;
         Y   <= '0;
      end else begin
         idx <= idx_next;
         Y   <= y_next;
      end
   end

   assign BUSY    = 1'b0;
   assign WRAPPED = 1'b0;
`endif

endmodule

// File: tb/tb_decnx_seq.sv
// tb/tb_decnx_seq.sv - vector-table bench for decnx_seq (N=3); scan vectors only when
// DECNX_SCAN_EN is defined.
module tb_decnx_seq;

   logic       clk = 1'b0;
   logic       rstb = 1'b0;
   logic [2:0] a = '0;
   logic       load = 1'b0;
   logic       en = 1'b0;
   logic       scan = 1'b0;
   logic [3:0] div = '0;
   logic [7:0] y;
   logic [2:0] idx;
   logic       busy;
   logic       wrapped;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rstb;
      logic       load;
      logic [2:0] a;
      logic       en;
      logic       scan;
      logic [3:0] div;
      logic [7:0] y;
      logic [2:0] idx;
      logic       busy;
      logic       wrap;
      string      name;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   decnx_seq #(.N(3), .DIV_W(4)) dut (
      .CLK(clk), .RSTB(rstb), .A(a), .LOAD(load), .EN(en), .SCAN(scan), .DIV(div),
      .Y(y), .IDX(idx), .BUSY(busy), .WRAPPED(wrapped)
   );

   always #5 clk = ~clk;

   function automatic vec_t v(input logic r, input logic l, input logic [2:0] aa,
                              input logic e, input logic s, input logic [3:0] d,
                              input logic [7:0] ey, input logic [2:0] ei,
                              input logic eb, input logic ew, input string nm);
      vec_t t;
      t.rstb = r; t.load = l; t.a = aa; t.en = e; t.scan = s; t.div = d;
      t.y = ey; t.idx = ei; t.busy = eb; t.wrap = ew; t.name = nm;
      return t;
   endfunction

   task automatic chk(input string nm, input int n, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s vec %0d got %h expected %h", nm, n, got, exp);
      end
   endtask

   task automatic run_vec(input int n);
      vec_t e;
      @(negedge clk);
      rstb = tbl[n].rstb; load = tbl[n].load; a = tbl[n].a;
      en = tbl[n].en; scan = tbl[n].scan; div = tbl[n].div;
      sb.push_back(tbl[n]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({e.name, ".y"}, n, y, e.y);
      chk({e.name, ".idx"}, n, {5'd0, idx}, {5'd0, e.idx});
      chk({e.name, ".busy"}, n, {7'd0, busy}, {7'd0, e.busy});
      chk({e.name, ".wrapped"}, n, {7'd0, wrapped}, {7'd0, e.wrap});
   endtask

   initial begin
      //                 rstb load a en scan div   y     idx busy wrap
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, "reset0"));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, "reset1"));
      tbl.push_back(v(1, 1, 5, 1, 0, 0, 8'h20, 5, 0, 0, "load5"));
      tbl.push_back(v(1, 0, 0, 1, 0, 0, 8'h20, 5, 0, 0, "hold5"));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 8'h00, 5, 0, 0, "en_off0"));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 8'h00, 5, 0, 0, "en_off1"));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 8'h00, 5, 0, 0, "en_off2"));
      tbl.push_back(v(1, 0, 0, 1, 0, 0, 8'h20, 5, 0, 0, "en_on"));
      tbl.push_back(v(1, 1, 0, 1, 0, 0, 8'h01, 0, 0, 0, "load0_nowrap"));
      tbl.push_back(v(1, 1, 7, 0, 0, 0, 8'h00, 7, 0, 0, "load7_en_off"));
      tbl.push_back(v(1, 0, 0, 1, 0, 0, 8'h80, 7, 0, 0, "show7"));
      tbl.push_back(v(1, 1, 3, 1, 0, 0, 8'h08, 3, 0, 0, "load3"));
      tbl.push_back(v(0, 1, 6, 1, 0, 0, 8'h00, 0, 0, 0, "reset_over_load"));
      tbl.push_back(v(1, 0, 0, 1, 0, 0, 8'h01, 0, 0, 0, "after_reset"));
`ifdef DECNX_SCAN_EN
      // DIV=0: one step per cycle, wrap pulse with Y=0x01
      tbl.push_back(v(1, 1, 6, 1, 0, 0, 8'h40, 6, 0, 0, "d0_load6"));
      tbl.push_back(v(1, 0, 0, 1, 1, 0, 8'h40, 6, 1, 0, "d0_enter"));
      tbl.push_back(v(1, 0, 0, 1, 1, 0, 8'h80, 7, 1, 0, "d0_step7"));
      tbl.push_back(v(1, 0, 0, 1, 1, 0, 8'h01, 0, 1, 1, "d0_wrap"));
      tbl.push_back(v(1, 0, 0, 1, 1, 0, 8'h02, 1, 1, 0, "d0_step1"));
      tbl.push_back(v(1, 0, 0, 1, 0, 0, 8'h02, 1, 0, 0, "d0_leave"));
      // DIV=2: one step every 3 cycles, LOAD coincident with a step wins
      tbl.push_back(v(1, 1, 0, 1, 0, 2, 8'h01, 0, 0, 0, "d2_load0"));
      tbl.push_back(v(1, 0, 0, 1, 1, 2, 8'h01, 0, 1, 0, "d2_enter"));
      tbl.push_back(v(1, 0, 0, 1, 1, 2, 8'h01, 0, 1, 0, "d2_c1"));
      tbl.push_back(v(1, 0, 0, 1, 1, 2, 8'h01, 0, 1, 0, "d2_c2"));
      tbl.push_back(v(1, 0, 0, 1, 1, 2, 8'h02, 1, 1, 0, "d2_step1"));
      tbl.push_back(v(1, 0, 0, 1, 1, 2, 8'h02, 1, 1, 0, "d2_c1b"));
      tbl.push_back(v(1, 0, 0, 1, 1, 2, 8'h02, 1, 1, 0, "d2_c2b"));
      tbl.push_back(v(1, 1, 3, 1, 1, 2, 8'h08, 3, 1, 0, "d2_load3_vs_step"));
      tbl.push_back(v(1, 0, 0, 1, 1, 2, 8'h08, 3, 1, 0, "d2_c1c"));
      tbl.push_back(v(1, 0, 0, 1, 1, 2, 8'h08, 3, 1, 0, "d2_c2c"));
      tbl.push_back(v(1, 0, 0, 1, 1, 2, 8'h10, 4, 1, 0, "d2_step4"));
      // reset mid-scan, then re-entry with SCAN still high
      tbl.push_back(v(0, 0, 0, 1, 1, 2, 8'h00, 0, 0, 0, "rst_mid_scan"));
      tbl.push_back(v(1, 0, 0, 1, 1, 2, 8'h01, 0, 1, 0, "rescan"));
      // EN low freezes idx/cnt, BUSY stays
      tbl.push_back(v(1, 0, 0, 1, 1, 2, 8'h01, 0, 1, 0, "en_c1"));
      tbl.push_back(v(1, 0, 0, 0, 1, 2, 8'h00, 0, 1, 0, "en_freeze0"));
      tbl.push_back(v(1, 0, 0, 0, 1, 2, 8'h00, 0, 1, 0, "en_freeze1"));
      tbl.push_back(v(1, 0, 0, 1, 1, 2, 8'h01, 0, 1, 0, "en_c2"));
      tbl.push_back(v(1, 0, 0, 1, 1, 2, 8'h02, 1, 1, 0, "en_step1"));
      // lowering DIV below cnt steps on the next enabled cycle
      tbl.push_back(v(1, 0, 0, 1, 1, 2, 8'h02, 1, 1, 0, "div_c1"));
      tbl.push_back(v(1, 0, 0, 1, 1, 0, 8'h04, 2, 1, 0, "div_lowered"));
      tbl.push_back(v(1, 0, 0, 1, 0, 0, 8'h04, 2, 0, 0, "scan_exit"));
`else
      // scan inputs have no effect without the scan feature
      tbl.push_back(v(1, 1, 2, 1, 0, 0, 8'h04, 2, 0, 0, "noscan_load2"));
      for (int i = 0; i < 10; i++)
         tbl.push_back(v(1, 0, 0, 1, 1, 0, 8'h04, 2, 0, 0, "noscan_hold"));
`endif
      for (int i = 0; i < tbl.size(); i++)
         run_vec(i);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got no finish expected finish");
      $fatal(1);
   end

endmodule
